// File: rtl/lane_mem_scaler_if.sv
// lane_mem_scaler_if: request/response bundle for lane_mem_scaler.
//   master : drives read/write requests and scale commands, observes results
//   slave  : the memory; returns the registered read row, busy/done status
//            and the flat debug view of every row
// Ports carried:
//   i_rd_en, i_wr_en, i_address, i_lane_mask, i_write_data   row access
//   o_read_data, o_rd_valid                                  read response
//   i_scale_start, i_scale_first, i_scale_last, i_scale_shift scale command
//   o_busy, o_done                                           scale status
//   o_mem                                                    debug view
interface lane_mem_scaler_if #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned LANES    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned SHIFT_W  = $clog2(DATA_LEN) + 1
);
  logic                              i_rd_en;
  logic                              i_wr_en;
  logic [ADDR_W-1:0]                 i_address;
  logic [LANES-1:0]                  i_lane_mask;
  logic [DATA_LEN*LANES-1:0]         i_write_data;
  logic [DATA_LEN*LANES-1:0]         o_read_data;
  logic                              o_rd_valid;
  logic                              i_scale_start;
  logic [ADDR_W-1:0]                 i_scale_first;
  logic [ADDR_W-1:0]                 i_scale_last;
  logic [SHIFT_W-1:0]                i_scale_shift;
  logic                              o_busy;
  logic                              o_done;
  logic [DATA_LEN*LANES*DEPTH-1:0]   o_mem;

  modport master (
    output i_rd_en, i_wr_en, i_address, i_lane_mask, i_write_data,
           i_scale_start, i_scale_first, i_scale_last, i_scale_shift,
    input  o_read_data, o_rd_valid, o_busy, o_done, o_mem
  );

  modport slave (
    input  i_rd_en, i_wr_en, i_address, i_lane_mask, i_write_data,
           i_scale_start, i_scale_first, i_scale_last, i_scale_shift,
    output o_read_data, o_rd_valid, o_busy, o_done, o_mem
  );
endinterface

// File: rtl/lane_mem_scaler.sv
// lane_mem_scaler: DEPTH rows of LANES x DATA_LEN-bit words with lane-masked
// writes, a registered valid-flagged read port, and a scale engine that
// left-shifts every lane of a (possibly wrapping) row range in place, one
// row per cycle.
// Ports:
//   i_clk   clock, all state on rising edge
//   i_rstn  asynchronous active-low reset; reloads the ramp into the rows
//   bus     lane_mem_scaler_if.slave (access, scale command, status, debug)
module lane_mem_scaler #(
  parameter int unsigned DATA_LEN  = 32,
  parameter int unsigned LANES     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned INIT_ROWS = 8,
  parameter int unsigned SHIFT_W   = $clog2(DATA_LEN) + 1
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  lane_mem_scaler_if.slave    bus
);

  localparam int unsigned ROW_W   = DATA_LEN * LANES;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef logic [LANES-1:0][DATA_LEN-1:0] row_t;
  typedef enum logic [1:0] {IDLE, SCALE, DONE} state_t;

  state_t              state;
  row_t                mem [DEPTH];
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   sc_last;
  logic [SHIFT_W-1:0]  sc_shift;
  logic [ROW_W-1:0]    read_data;
  logic                rd_valid;
  logic                busy;
  logic                done;

  // DEPTH need not be a power of two, so addresses are range-checked
  logic addr_ok, first_ok, last_ok;
  assign addr_ok  = 32'(bus.i_address)     < DEPTH_W;
  assign first_ok = 32'(bus.i_scale_first) < DEPTH_W;
  assign last_ok  = 32'(bus.i_scale_last)  < DEPTH_W;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        for (int unsigned j = 0; j < LANES; j++) begin
          mem[r][j] <= (r < INIT_ROWS) ? DATA_LEN'(r * LANES + j) : '0;
        end
      end
      state     <= IDLE;
      ptr       <= '0;
      sc_last   <= '0;
      sc_shift  <= '0;
      read_data <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          // read samples the row before any same-cycle write lands
          if (bus.i_rd_en) begin
            read_data <= addr_ok ? mem[bus.i_address] : '0;
            rd_valid  <= 1'b1;
          end
          if (bus.i_wr_en && addr_ok) begin
            for (int unsigned j = 0; j < LANES; j++) begin
              if (bus.i_lane_mask[j])
                mem[bus.i_address][j] <= bus.i_write_data[DATA_LEN*j +: DATA_LEN];
            end
          end
          if (bus.i_scale_start && first_ok && last_ok) begin
            state    <= SCALE;
            ptr      <= bus.i_scale_first;
            sc_last  <= bus.i_scale_last;
            sc_shift <= bus.i_scale_shift;
            busy     <= 1'b1;
          end
        end
        SCALE: begin
          // shifts >= DATA_LEN naturally clear the lane
          for (int unsigned j = 0; j < LANES; j++) begin
            mem[ptr][j] <= mem[ptr][j] << sc_shift;
          end
          if (ptr == sc_last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            ptr <= (32'(ptr) == DEPTH_W - 32'd1) ? '0 : ptr + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.o_mem = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      bus.o_mem[ROW_W*r +: ROW_W] = mem[r];
    end
  end

  assign bus.o_read_data = read_data;
  assign bus.o_rd_valid  = rd_valid;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;

endmodule
